// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared datapath width and sequencer state encoding
//
// Purpose: constants shared by the multi-cycle arithmetic blocks.
// Ports:   none (package).

package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_cr_chunk.sv
// rtl/add_cr_chunk.sv - combinational CHUNK-bit ripple-carry adder slice
//
// Purpose: adds two CHUNK-bit slices plus a carry-in using a chain of
//          full-adder cells.
// Ports:   a, b  - slice operands (CHUNK bits)
//          cin   - carry into bit 0
//          s     - slice sum (CHUNK bits)
//          cout  - carry out of the top bit

module add_cr_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/add_cr32_seq.sv
// rtl/add_cr32_seq.sv - multi-cycle 32-bit adder, one CHUNK-bit slice per clock
//
// Purpose: computes op1 + op2 + ci over WIDTH/CHUNK cycles with a registered
//          carry between slices; valid/ready handshakes on both sides.
// Ports:   clk, rst_n          - clock, asynchronous active-low reset
//          in_valid, in_ready  - operand handshake
//          op1, op2, ci        - augend, addend, carry-in
//          out_valid, out_ready- result handshake
//          sum, co, ovf        - result, unsigned carry-out, signed overflow

module add_cr32_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] s_slice;
    logic             c_slice;
    logic [WIDTH-1:0] s_ext;

    // Operand registers shift right after each slice, so the active slice
    // is always the low CHUNK bits and the last slice carries bit 31.
    add_cr_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (op1_q[CHUNK-1:0]),
        .b    (op2_q[CHUNK-1:0]),
        .cin  (carry_q),
        .s    (s_slice),
        .cout (c_slice)
    );

    assign s_ext = WIDTH'(s_slice);

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op1_d   = op1;
                    op2_d   = op2;
                    carry_d = ci;
                    k_d     = '0;
                    // Uncomputed slices must read as zero while busy.
                    sum_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                op1_d   = op1_q >> CHUNK;
                op2_d   = op2_q >> CHUNK;
                carry_d = c_slice;
                sum_d   = sum_q | (s_ext << (int'(k_q) * CHUNK));
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NSLICE - 1)) begin
                    k_d     = '0;
                    co_d    = c_slice;
                    // Top bits of the final slice are the operand sign bits.
                    ovf_d   = (op1_q[CHUNK-1] == op2_q[CHUNK-1]) &&
                              (s_slice[CHUNK-1] != op1_q[CHUNK-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/add_cr32_seq.md
Name: add_cr32_seq

Overview:
Multi-cycle 32-bit ripple-carry adder. It is the additive counterpart of the borrow-ripple subtractor: it computes op1 + op2 + ci one CHUNK-bit slice per clock, using a registered carry between slices. Operands are accepted and results returned over valid/ready handshakes, so it can sit in a datapath next to the subtractor and trade latency for a short carry chain.

Parameters:
- WIDTH, 32, operand/result width; fixed at 32 in this revision.
- CHUNK, 8, bits added per cycle; must divide WIDTH (legal: 1, 2, 4, 8, 16, 32).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and ci valid.
- in_ready  output  1  block can accept operands.
- op1  input  32  augend.
- op2  input  32  addend.
- ci  input  1  carry-in.
- out_valid  output  1  sum, co and ovf valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  32  op1 + op2 + ci, modulo 2^32.
- co  output  1  unsigned carry-out of bit 31.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, co=0, ovf=0. The carry register, slice counter and operand registers clear to 0.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid && in_ready at edge T:
  - latch op1, op2 and ci (ci goes into the carry register);
  - clear slice index k to 0;
  - go to BUSY.
- BUSY: in_ready=0. Each edge adds slice k:
  - sum[k*CHUNK +: CHUNK] = a_slice + b_slice + carry;
  - carry <= slice carry-out;
  - k increments.
- After slice WIDTH/CHUNK-1, go to DONE.
- Latency: out_valid rises after edge T + WIDTH/CHUNK. With CHUNK=8 that is 4 edges after acceptance. CHUNK=32 gives 1 edge.
- DONE: out_valid=1. sum, co and ovf are stable until the handshake completes.
  - co = final carry.
  - ovf = (op1[31] == op2[31]) && (sum[31] != op1[31]).
- Handshake is complete on out_valid && out_ready. Next state is IDLE, out_valid=0.
- sum, co and ovf hold their last value in IDLE; they are meaningful only while out_valid=1.
- No overlap: in_ready=0 in BUSY and DONE. Minimum issue interval is WIDTH/CHUNK + 2 cycles.
- Input stability: op1, op2 and ci are sampled only at the accept edge. Later changes have no effect.
- Backpressure: if out_ready stays low, DONE is held indefinitely and outputs do not change.
- in_valid asserted outside IDLE is ignored; no implicit queuing.
- Reset mid-operation (BUSY or DONE): the operation is discarded and all registers return to reset values immediately. No out_valid pulse is produced for that operation.
- Width rules:
  - all arithmetic is unsigned modulo 2^32;
  - co and ovf are each computed once, from the final slice;
  - sum bits for slices not yet computed read as 0 while BUSY.

Decomposition:
- Shared package (alu_pkg): WIDTH constant; state encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module, add_cr_chunk:
  - combinational CHUNK-bit ripple-carry adder built from full-adder cells;
  - ports a[CHUNK], b[CHUNK], cin → s[CHUNK], cout.
- add_cr32_seq holds the FSM, slice counter, carry register and operand/result registers, and instantiates one add_cr_chunk.

Test Plan:
- 7 + 4, ci=0, out_ready=1 → sum=0x0000000B, co=0, ovf=0; out_valid rises exactly 4 edges after accept (CHUNK=8).
- 7 + 4, ci=1 → sum=0x0000000C, co=0, ovf=0.
- 0xFFFFFFFF + 0x00000000, ci=1 → sum=0x00000000, co=1, ovf=0. Confirms the carry ripples through all four slices.
- 0x7FFFFFFF + 0x00000001, ci=0 → sum=0x80000000, co=0, ovf=1. Also 0x80000007 + 0x80000004 → sum=0x0000000B, co=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0. Pulse out_ready=1 → out_valid=0 and in_ready=1 next cycle. A new operation is accepted only after that.
- Reset mid-op: deassert rst_n two cycles into BUSY → outputs return to reset values asynchronously, with no out_valid. After release, a fresh 7 + 4 produces 0x0000000B normally.
